// File: rtl/morse_char_sequencer.sv
// rtl/morse_char_sequencer.sv - ASCII to International Morse LED sequencer with valid/ready input
// Optional MORSE_ERR_EN adds a one-cycle err pulse for unsupported characters.
module morse_char_sequencer #(
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       busy,
  output logic       led
`ifdef MORSE_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP} state_t;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       units_q, units_d;
  logic [4:0]       pat_q, pat_d;
  logic [2:0]       elems_q, elems_d;
  logic             led_q, led_d;
  logic             err_q, err_d;

  // Returns {supported, len, pattern}; pattern is left-aligned (bit 4 sent first), 1 = dash.
  // A space is reported as supported with len 0.
  function automatic logic [8:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      8'h41: lookup = {1'b1, 3'd2, 5'b01000};
      8'h42: lookup = {1'b1, 3'd4, 5'b10000};
      8'h43: lookup = {1'b1, 3'd4, 5'b10100};
      8'h44: lookup = {1'b1, 3'd3, 5'b10000};
      8'h45: lookup = {1'b1, 3'd1, 5'b00000};
      8'h46: lookup = {1'b1, 3'd4, 5'b00100};
      8'h47: lookup = {1'b1, 3'd3, 5'b11000};
      8'h48: lookup = {1'b1, 3'd4, 5'b00000};
      8'h49: lookup = {1'b1, 3'd2, 5'b00000};
      8'h4a: lookup = {1'b1, 3'd4, 5'b01110};
      8'h4b: lookup = {1'b1, 3'd3, 5'b10100};
      8'h4c: lookup = {1'b1, 3'd4, 5'b01000};
      8'h4d: lookup = {1'b1, 3'd2, 5'b11000};
      8'h4e: lookup = {1'b1, 3'd2, 5'b10000};
      8'h4f: lookup = {1'b1, 3'd3, 5'b11100};
      8'h50: lookup = {1'b1, 3'd4, 5'b01100};
      8'h51: lookup = {1'b1, 3'd4, 5'b11010};
      8'h52: lookup = {1'b1, 3'd3, 5'b01000};
      8'h53: lookup = {1'b1, 3'd3, 5'b00000};
      8'h54: lookup = {1'b1, 3'd1, 5'b10000};
      8'h55: lookup = {1'b1, 3'd3, 5'b00100};
      8'h56: lookup = {1'b1, 3'd4, 5'b00010};
      8'h57: lookup = {1'b1, 3'd3, 5'b01100};
      8'h58: lookup = {1'b1, 3'd4, 5'b10010};
      8'h59: lookup = {1'b1, 3'd4, 5'b10110};
      8'h5a: lookup = {1'b1, 3'd4, 5'b11000};
      8'h30: lookup = {1'b1, 3'd5, 5'b11111};
      8'h31: lookup = {1'b1, 3'd5, 5'b01111};
      8'h32: lookup = {1'b1, 3'd5, 5'b00111};
      8'h33: lookup = {1'b1, 3'd5, 5'b00011};
      8'h34: lookup = {1'b1, 3'd5, 5'b00001};
      8'h35: lookup = {1'b1, 3'd5, 5'b00000};
      8'h36: lookup = {1'b1, 3'd5, 5'b10000};
      8'h37: lookup = {1'b1, 3'd5, 5'b11000};
      8'h38: lookup = {1'b1, 3'd5, 5'b11100};
      8'h39: lookup = {1'b1, 3'd5, 5'b11110};
      8'h20: lookup = {1'b1, 3'd0, 5'b00000};
      default: lookup = 9'd0;
    endcase
  endfunction

  logic [8:0] lk;
  logic       accept, unit_done, seg_done;

  assign lk        = lookup(char_data);
  assign accept    = char_valid && (state_q == IDLE);
  assign unit_done = (cnt_q == UNIT_LAST);
  assign seg_done  = unit_done && (units_q == 3'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    pat_d   = pat_q;
    elems_d = elems_q;
    err_d   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = unit_done ? '0 : cnt_q + 1'b1;
      if (unit_done) units_d = units_q - 3'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (!lk[8]) begin
            err_d = 1'b1;
          end else if (lk[7:5] == 3'd0) begin
            state_d = WGAP;
            units_d = 3'd4;
          end else begin
            state_d = MARK;
            units_d = lk[4] ? 3'd3 : 3'd1;
            pat_d   = {lk[3:0], 1'b0};
            elems_d = lk[7:5] - 3'd1;
          end
        end
      end
      MARK: begin
        if (seg_done) begin
          if (elems_q != 3'd0) begin
            state_d = GAP;
            units_d = 3'd1;
          end else begin
            state_d = LGAP;
            units_d = 3'd3;
          end
        end
      end
      GAP: begin
        if (seg_done) begin
          state_d = MARK;
          units_d = pat_q[4] ? 3'd3 : 3'd1;
          pat_d   = {pat_q[3:0], 1'b0};
          elems_d = elems_q - 3'd1;
        end
      end
      LGAP, WGAP: begin
        if (seg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so the LED follows the state on the same edge, including the accept edge.
    led_d = (state_d == MARK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      units_q <= '0;
      pat_q   <= '0;
      elems_q <= '0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      pat_q   <= pat_d;
      elems_q <= elems_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign char_ready = ~busy;
  assign led        = led_q;

`ifdef MORSE_ERR_EN
  assign err = err_q;
`else
  logic err_unused;
  assign err_unused = err_q;
`endif

endmodule

// File: tb/tb_morse_char_sequencer.sv
// tb/tb_morse_char_sequencer.sv - self-checking bench for morse_char_sequencer (UNIT_CYCLES=4)
// Model expands each accepted character into a queue of expected LED levels.
module tb_morse_char_sequencer;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready, busy, led;
`ifdef MORSE_ERR_EN
  logic       err;
`endif

  int total = 0;
  int bad = 0;
  int led_cnt = 0;
  int busy_cnt = 0;

  bit q[$];
  bit m_led = 1'b0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;

  morse_char_sequencer #(.UNIT_CYCLES(U), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .busy(busy), .led(led)
`ifdef MORSE_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string code_of(input byte c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      " ": return " ";
      default: return "";
    endcase
  endfunction

  task automatic push_n(input bit v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  // Reference model: expected LED level for every cycle after an accept edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_led = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      end else begin
        m_err = 1'b0;
        if (!m_busy && char_valid) begin
          byte c;
          string s;
          c = char_data;
          if (c >= "a" && c <= "z") c = c - 8'h20;
          s = code_of(c);
          if (s.len() == 0) m_err = 1'b1;
          else if (s == " ") push_n(1'b0, 4 * U);
          else begin
            for (int i = 0; i < s.len(); i++) begin
              push_n(1'b1, (s[i] == "-") ? 3 * U : U);
              push_n(1'b0, (i == s.len() - 1) ? 3 * U : U);
            end
          end
        end
        if (q.size() > 0) begin m_led = q.pop_front(); m_busy = 1'b1; end
        else begin m_led = 1'b0; m_busy = 1'b0; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("led", led, m_led);
      chk("busy", busy, m_busy);
      chk("char_ready", char_ready, !m_busy);
`ifdef MORSE_ERR_EN
      chk("err", err, m_err);
`endif
      if (led) led_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic send_char(input byte c);
    int n;
    n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data = c;
    while (!char_ready && n < 200) begin @(negedge clk); n++; end
    if (!char_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Drops valid and returns the number of cycles after the accept edge until char_ready.
  task automatic drop_and_wait(output int k);
    @(negedge clk);
    char_valid = 1'b0;
    k = 1;
    while (!char_ready && k < 300) begin @(negedge clk); k++; end
    #1;
  endtask

  task automatic clear_cnts();
    led_cnt = 0;
    busy_cnt = 0;
  endtask

  initial begin
    int k;
    string msg;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_led", led, 0);
    chk("reset_ready", char_ready, 1);
    chk("reset_busy", busy, 0);

    send_char("E"); clear_cnts();
    drop_and_wait(k);
    chk("E_ready_cycle", k, 17);
    chk("E_led_cycles", led_cnt, 4);
    chk("E_busy_cycles", busy_cnt, 16);

    send_char("T"); clear_cnts();
    drop_and_wait(k);
    chk("T_ready_cycle", k, 25);
    chk("T_led_cycles", led_cnt, 12);

    send_char("S"); clear_cnts();
    send_char("O");
    send_char("S");
    drop_and_wait(k);
    chk("SOS_busy_cycles", busy_cnt, 120);
    chk("SOS_led_cycles", led_cnt, 60);

    send_char("s"); clear_cnts();
    send_char(" ");
    send_char("E");
    drop_and_wait(k);
    chk("s_sp_E_busy_cycles", busy_cnt, 64);
    chk("s_sp_E_led_cycles", led_cnt, 16);

    send_char("#");
    @(negedge clk);
    char_valid = 1'b0;
    #1;
    chk("hash_ready", char_ready, 1);
    chk("hash_led", led, 0);
`ifdef MORSE_ERR_EN
    chk("hash_err_pulse", err, 1);
    @(negedge clk); #1;
    chk("hash_err_clear", err, 0);
`endif

    send_char("T"); clear_cnts();
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_led", led, 0);
    chk("abort_ready", char_ready, 1);
    @(negedge clk);
    char_valid = 1'b0;
    rst = 1'b1;
    clear_cnts();
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_pulses", led_cnt, 0);

    msg = "A9z0";
    for (int i = 0; i < msg.len(); i++) send_char(msg[i]);
    drop_and_wait(k);
    chk("mixed_done", char_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
